alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Shares the single-cycle 32-bit ALU between two requesters (e.g. the execute stage and a multi-cycle helper) using round-robin arbitration and valid/ready handshakes.
- Issues each accepted op to the ALU over its I1/I2/Selector ports and captures the ALU output.
- Splits variable rotates (rolv/rorv, amount 0-31) into several ALU passes, because the ALU rotates at most MAX_STEP bits per pass.
- Sits between the requesters and the ALU instance; the ALU stays purely combinational.

Parameters:
- WIDTH, 32, data width of operands and result.
- MAX_STEP, 7, largest rotate amount the ALU applies in one pass.
- AMT_BITS, 5, width of the rotate amount field, taken from a[AMT_BITS-1:0].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle when valid & ready.
- req0_sel  in  5  ALU selector code.
- req0_a  in  WIDTH  operand I1; holds the rotate amount for rotates.
- req0_b  in  WIDTH  operand I2; holds the value to rotate for rotates.
- req1_valid, req1_ready, req1_sel, req1_a, req1_b: same as the requester 0 ports, for requester 1.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  index of the requester that issued the op.
- rsp_data  out  WIDTH  result.
- alu_i1  out  WIDTH  drives ALU I1.
- alu_i2  out  WIDTH  drives ALU I2.
- alu_sel  out  5  drives ALU Selector.
- alu_o  in  WIDTH  ALU output, combinational from alu_i1/alu_i2/alu_sel.

Behaviour:
- Selector encodings: add 10000, nor 10011, nori 00111, not 00010, bleu 01000, rolv 00000, rorv 00001.
- Rotate ops are rolv and rorv. Every other code, including undefined codes, is a single-pass op.
- Reset values: state IDLE; rsp_valid 0; rsp_data 0; rsp_id 0; last_grant 1 (so requester 0 wins the first tie); alu_i1, alu_i2 and alu_sel all 0.
- A reset asserted mid-operation aborts the op, produces no response, and restores the reset values on the next edge.

State machine:
- IDLE:
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the requester that is not last_grant.
  - reqN_ready = (state==IDLE) & grant==N. It is combinational and never asserted for both requesters.
  - On accept: latch sel, a, b and id; last_grant <= id.
  - Next state: a non-rotate op goes to EXEC. A rotate with amount a[4:0]==0 goes to DONE with result = b and no ALU pass. Any other rotate goes to ROT with rem = a[4:0] and acc = b.
- EXEC:
  - Drive alu_i1 = a, alu_i2 = b, alu_sel = sel.
  - result <= alu_o; go to DONE.
- ROT:
  - chunk = min(rem, MAX_STEP).
  - Drive alu_i1 = zero-extended chunk, alu_i2 = acc, alu_sel = sel.
  - acc <= alu_o; rem <= rem - chunk.
  - When rem - chunk == 0: result <= alu_o and go to DONE.
  - Pass count is ceil(amount/MAX_STEP): amount 31 takes 5 passes, amount 7 takes 1, amount 8 takes 2.
- DONE:
  - rsp_valid = 1; rsp_data = result and rsp_id = id are held stable while rsp_ready = 0.
  - On rsp_ready go to IDLE. A new request can be accepted the following cycle, so there is no overlap.
- ALU port outputs are 0 whenever the state is not EXEC or ROT.

Timing:
- Latency from accept to rsp_valid: 2 cycles for a non-rotate op; 1 + passes cycles for a rotate; 1 cycle for a rotate by 0.
- A requester whose valid drops while it is not granted loses nothing; no request is latched without a handshake.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,...

Test Plan:
- The bench instantiates a behavioural ALU implementing the encodings above.
- Add: req0 sel 10000, a 0xFFFFFFFF, b 0x00000001 -> rsp_valid 2 cycles after accept, rsp_data 0x00000000, rsp_id 0.
- Tie arbitration: req0 and req1 valid together, continuously, with rsp_ready=1 -> acceptance order 0,1,0,1; each response has the matching id.
- Multi-pass rotate: req1 sel 00001 (rorv), a 17, b 0x00000001 -> ALU sees chunks 7, 7, 3 on consecutive cycles; rsp_data 0x00008000 at 4 cycles after accept.
- Rotate by zero: sel 00000 (rolv), a 32 (so a[4:0]=0), b 0xDEADBEEF -> no ALU pass (alu_sel/alu_i1/alu_i2 stay 0); rsp_data 0xDEADBEEF 1 cycle after accept.
- Backpressure: rsp_ready held 0 for 5 cycles after an nor of a 0x0F0F0F0F, b 0x00FF00FF -> rsp_data holds 0xF000F000 throughout, both readies stay 0, no new accept until the cycle after rsp_ready rises.
- Reset mid-rotate: assert reset during the second ROT pass -> next cycle state IDLE, rsp_valid 0, ALU ports 0, and the next tie is granted to req0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Round-robin front end for a shared combinational ALU: accepts one op at a time
// from two requesters, splits variable rotates into bounded passes, returns the result.
module alu_op_sequencer #(
   parameter int WIDTH    = 32,
   parameter int MAX_STEP = 7,
   parameter int AMT_BITS = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [4:0]       req0_sel,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [4:0]       req1_sel,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic [WIDTH-1:0] alu_i1,
   output logic [WIDTH-1:0] alu_i2,
   output logic [4:0]       alu_sel,
   input  logic [WIDTH-1:0] alu_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_ROT  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [4:0]          SEL_ROLV = 5'b00000;
   localparam logic [4:0]          SEL_RORV = 5'b00001;
   localparam logic [AMT_BITS-1:0] STEP     = AMT_BITS'(MAX_STEP);

   logic [1:0]          state;
   logic [4:0]          sel_q;
   logic [WIDTH-1:0]    a_q;
   logic [WIDTH-1:0]    b_q;      // also the rotate accumulator
   logic [WIDTH-1:0]    result;
   logic                id_q;
   logic                last_grant;
   logic [AMT_BITS-1:0] rem;

   logic                gnt_valid;
   logic                gnt_id;
   logic [4:0]          sel_in;
   logic [WIDTH-1:0]    a_in;
   logic [WIDTH-1:0]    b_in;
   logic                is_rot;
   logic [AMT_BITS-1:0] amt;
   logic [AMT_BITS-1:0] chunk;

   // A tie goes to whoever did not win last; otherwise the lone valid requester.
   always_comb begin
      gnt_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) gnt_id = ~last_grant;
      else                          gnt_id = req1_valid;
   end

   assign req0_ready = (state == S_IDLE) && gnt_valid && !gnt_id;
   assign req1_ready = (state == S_IDLE) && gnt_valid &&  gnt_id;

   assign sel_in = gnt_id ? req1_sel : req0_sel;
   assign a_in   = gnt_id ? req1_a   : req0_a;
   assign b_in   = gnt_id ? req1_b   : req0_b;
   assign is_rot = (sel_in == SEL_ROLV) || (sel_in == SEL_RORV);
   assign amt    = a_in[AMT_BITS-1:0];
   assign chunk  = (rem > STEP) ? STEP : rem;

   always_comb begin
      alu_i1  = '0;
      alu_i2  = '0;
      alu_sel = '0;
      case (state)
         S_EXEC: begin
            alu_i1  = a_q;
            alu_i2  = b_q;
            alu_sel = sel_q;
         end
         S_ROT: begin
            alu_i1  = WIDTH'(chunk);
            alu_i2  = b_q;
            alu_sel = sel_q;
         end
         default: ;
      endcase
   end

   assign rsp_valid = (state == S_DONE);
   assign rsp_data  = result;
   assign rsp_id    = id_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         sel_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         result     <= '0;
         id_q       <= 1'b0;
         last_grant <= 1'b1;
         rem        <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gnt_valid) begin
                  sel_q      <= sel_in;
                  a_q        <= a_in;
                  b_q        <= b_in;
                  id_q       <= gnt_id;
                  last_grant <= gnt_id;
                  if (!is_rot) begin
                     state <= S_EXEC;
                  end else if (amt == '0) begin
                     result <= b_in;
                     state  <= S_DONE;
                  end else begin
                     rem   <= amt;
                     state <= S_ROT;
                  end
               end
            end
            S_EXEC: begin
               result <= alu_o;
               state  <= S_DONE;
            end
            S_ROT: begin
               b_q <= alu_o;
               rem <= rem - chunk;
               if (rem == chunk) begin
                  result <= alu_o;
                  state  <= S_DONE;
               end
            end
            default: begin
               if (rsp_ready) state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, directed table, corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_alu_op_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [4:0]  req0_sel = '0, req1_sel = '0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic        rsp_valid, rsp_id;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_data, alu_i1, alu_i2, alu_o;
   logic [4:0]  alu_sel;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_op_sequencer #(.WIDTH(32), .MAX_STEP(7), .AMT_BITS(5)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_sel(alu_sel), .alu_o(alu_o)
   );

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      int k = n % 32;
      return (k == 0) ? x : ((x << k) | (x >> (32 - k)));
   endfunction

   // Architectural result of an op; rotates are done in one step here.
   function automatic logic [31:0] ref_op(input logic [4:0] s, input logic [31:0] a, input logic [31:0] b);
      case (s)
         5'b10000: return a + b;
         5'b10011: return ~(a | b);
         5'b00111: return ~(a | b);
         5'b00010: return ~a;
         5'b01000: return (a <= b) ? 32'd1 : 32'd0;
         5'b00000: return rotl(b, int'(a[4:0]));
         5'b00001: return rotl(b, (32 - int'(a[4:0])) % 32);
         default:  return a ^ b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [4:0] s, input logic [31:0] a);
      int amt = int'(a[4:0]);
      if (s != 5'b00000 && s != 5'b00001) return 2;
      if (amt == 0) return 1;
      return 1 + (amt + 6) / 7;
   endfunction

   assign alu_o = ref_op(alu_sel, alu_i1, alu_i2);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   logic [31:0] chunk_log [0:15];

   // Issues one op on requester rid and checks latency, data, id, idle ALU ports.
   task automatic run_op(input bit rid, input logic [4:0] s, input logic [31:0] a,
                         input logic [31:0] b, input string nm);
      int n = 0;
      bit got = 0;
      if (rid) begin req1_valid = 1; req1_sel = s; req1_a = a; req1_b = b; end
      else     begin req0_valid = 1; req0_sel = s; req0_a = a; req0_b = b; end
      for (int t = 0; t < 20 && !got; t++) begin
         @(negedge clk);
         if (rid ? req1_ready : req0_ready) got = 1;
         else begin @(posedge clk); #1; end
      end
      chk({nm, "_accept"}, 32'(got), 32'd1);
      chk({nm, "_idle_alu"}, alu_i1 | alu_i2 | 32'(alu_sel), 32'd0);
      @(posedge clk);
      #1 req0_valid = 0; req1_valid = 0;
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         n++;
         if (n < 16) chunk_log[n] = alu_i1;
         if (rsp_valid) break;
         @(posedge clk);
         #1;
      end
      chk({nm, "_lat"}, 32'(n), 32'(ref_lat(s, a)));
      chk({nm, "_data"}, rsp_data, ref_op(s, a, b));
      chk({nm, "_id"}, 32'(rsp_id), 32'(rid));
      chk({nm, "_done_alu"}, alu_i1 | alu_i2 | 32'(alu_sel), 32'd0);
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          rid;
      logic [4:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_data;
      int          exp_lat;
   } vec_t;

   vec_t vecs [0:9];

   initial begin
      int order [0:3];
      int n_acc, n_rsp;
      logic [4:0] sels [0:7];
      bit m_busy, m_last, m_id;
      int m_done, cyc;
      logic [31:0] m_res;

      vecs[0] = '{0, 5'b10000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2};
      vecs[1] = '{1, 5'b00001, 32'd17,        32'h0000_0001, 32'h0000_8000, 4};
      vecs[2] = '{0, 5'b00000, 32'd32,        32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
      vecs[3] = '{1, 5'b10011, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 2};
      vecs[4] = '{0, 5'b00010, 32'h1234_5678, 32'h0,         32'hEDCB_A987, 2};
      vecs[5] = '{1, 5'b01000, 32'd5,         32'd5,         32'd1,         2};
      vecs[6] = '{0, 5'b00000, 32'd31,        32'h8000_0001, 32'hC000_0000, 6};
      vecs[7] = '{0, 5'b00000, 32'd7,         32'h0000_0001, 32'h0000_0080, 2};
      vecs[8] = '{1, 5'b00001, 32'd8,         32'h0000_0100, 32'h0000_0001, 3};
      vecs[9] = '{0, 5'b00111, 32'hF0F0_0000, 32'h0000_000F, 32'h0F0F_FFF0, 2};

      do_reset();
      @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_alu", alu_i1 | alu_i2 | 32'(alu_sel), 32'd0);
      chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         chk($sformatf("vec%0d_model", i), ref_op(vecs[i].sel, vecs[i].a, vecs[i].b), vecs[i].exp_data);
         chk($sformatf("vec%0d_latmodel", i), 32'(ref_lat(vecs[i].sel, vecs[i].a)), 32'(vecs[i].exp_lat));
         run_op(vecs[i].rid, vecs[i].sel, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      end

      // rorv by 17 must be split into passes of 7, 7, 3
      run_op(1, 5'b00001, 32'd17, 32'h0000_0001, "rorv17");
      chk("rorv17_chunk1", chunk_log[1], 32'd7);
      chk("rorv17_chunk2", chunk_log[2], 32'd7);
      chk("rorv17_chunk3", chunk_log[3], 32'd3);

      // Backpressure: result holds, no new accept while DONE
      rsp_ready = 0;
      req0_valid = 1; req0_sel = 5'b10011; req0_a = 32'h0F0F_0F0F; req0_b = 32'h00FF_00FF;
      @(negedge clk);
      chk("bp_accept", 32'(req0_ready), 32'd1);
      @(posedge clk);
      #1 req0_sel = 5'b10000; req1_valid = 1; req1_sel = 5'b10000;
      @(posedge clk);
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         chk("bp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_data", rsp_data, 32'hF000_F000);
         chk("bp_ready", 32'({req0_ready, req1_ready}), 32'd0);
         @(posedge clk);
      end
      #1 rsp_ready = 1;
      @(negedge clk);
      chk("bp_release_ready", 32'({req0_ready, req1_ready}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_next_grant", 32'({req0_ready, req1_ready}), 32'b01);

      // Tie arbitration from reset: 0,1,0,1
      do_reset();
      req0_valid = 1; req0_sel = 5'b10000; req0_a = 32'd1;  req0_b = 32'd1;
      req1_valid = 1; req1_sel = 5'b10000; req1_a = 32'd10; req1_b = 32'd20;
      n_acc = 0;
      n_rsp = 0;
      for (int t = 0; t < 40 && n_rsp < 4; t++) begin
         @(negedge clk);
         if (req0_ready && req1_ready) chk("tie_both_ready", 32'd1, 32'd0);
         if ((req0_ready || req1_ready) && n_acc < 4) begin
            order[n_acc] = req1_ready ? 1 : 0;
            n_acc++;
         end
         if (rsp_valid) begin
            if (n_rsp < n_acc) chk($sformatf("tie_rsp%0d_id", n_rsp), 32'(rsp_id), 32'(order[n_rsp]));
            chk($sformatf("tie_rsp%0d_data", n_rsp), rsp_data, rsp_id ? 32'd30 : 32'd2);
            n_rsp++;
         end
         @(posedge clk);
      end
      chk("tie_count", 32'(n_rsp), 32'd4);
      for (int i = 0; i < 4; i++) chk($sformatf("tie_order%0d", i), 32'(order[i]), 32'(i % 2));

      // Reset during the second ROT pass
      do_reset();
      req1_valid = 1; req1_sel = 5'b00001; req1_a = 32'd31; req1_b = 32'h1234_5678;
      @(negedge clk);
      chk("mr_accept", 32'(req1_ready), 32'd1);
      @(posedge clk);
      #1 req1_valid = 0;
      @(posedge clk);
      @(negedge clk);
      chk("mr_pass2", alu_i1, 32'd7);
      reset = 1;
      @(posedge clk);
      #1 reset = 0;
      req0_valid = 1; req0_sel = 5'b10000;
      req1_valid = 1; req1_sel = 5'b10000;
      @(negedge clk);
      chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("mr_alu", alu_i1 | alu_i2 | 32'(alu_sel), 32'd0);
      chk("mr_tie", 32'({req0_ready, req1_ready}), 32'b10);

      // Randomized run against transaction-level model
      do_reset();
      sels = '{5'b10000, 5'b10011, 5'b00111, 5'b00010, 5'b01000, 5'b00000, 5'b00001, 5'b11111};
      m_busy = 0; m_last = 1; m_id = 0; m_done = 0; m_res = '0;
      for (cyc = 0; cyc < 600; cyc++) begin
         bit e0, e1, ev;
         req0_valid = ($urandom_range(0, 2) != 0);
         req1_valid = ($urandom_range(0, 2) != 0);
         req0_sel = sels[$urandom_range(0, 7)];
         req1_sel = sels[$urandom_range(0, 7)];
         req0_a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
         req1_a = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom;
         req0_b = $urandom;
         req1_b = $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         e0 = !m_busy && req0_valid && (!req1_valid || m_last);
         e1 = !m_busy && req1_valid && (!req0_valid || !m_last);
         ev = m_busy && (cyc >= m_done);
         chk("rnd_ready", 32'({req0_ready, req1_ready}), 32'({e0, e1}));
         chk("rnd_valid", 32'(rsp_valid), 32'(ev));
         if (ev) begin
            chk("rnd_data", rsp_data, m_res);
            chk("rnd_id", 32'(rsp_id), 32'(m_id));
         end
         if (ev && rsp_ready) m_busy = 0;
         if (e0 || e1) begin
            m_busy = 1;
            m_id   = e1;
            m_last = e1;
            m_done = cyc + (e1 ? ref_lat(req1_sel, req1_a) : ref_lat(req0_sel, req0_a));
            m_res  = e1 ? ref_op(req1_sel, req1_a, req1_b) : ref_op(req0_sel, req0_a, req0_b);
         end
         @(posedge clk);
         #1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
